// File: rtl/pkt_bufid_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_bufid_scheduler
//  Purpose  : Hands free buffer IDs from a shared free-bufid FIFO out to four
//             frame-parser ports. Each port raises a one-cycle refill request;
//             requests are remembered in a pending vector and served one at a
//             time in round-robin order. Every grant reads one bufid from the
//             FIFO, presents it on a shared bus with a one-hot write strobe,
//             and holds it until the granted port acknowledges.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MIN_FREE                    minimum FIFO fill level needed to start a fetch
//  Ports
//    clk_sys                     system clock, all state on rising edge
//    reset_n                     asynchronous active-low reset
//    iv_free_bufid_fifo_rdusedw  free-bufid FIFO fill level
//    o_free_bufid_fifo_rdreq     FIFO read request, one-cycle pulse
//    iv_free_bufid               FIFO read data, valid one cycle after rdreq
//    iv_bufid_req                per-port refill request pulses
//    o_pkt_bufid_wr              one-hot bufid write strobe, one bit per port
//    ov_pkt_bufid                bufid bus shared by all ports
//    i_pkt_bufid_ack             per-port acknowledge
//    ov_alloc_cnt                count of completed allocations (wraps)
//    ov_bufid_sched_state        current FSM state encoding
// ============================================================================
module pkt_bufid_scheduler #(
  parameter logic [8:0] MIN_FREE = 9'd1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [8:0]  iv_free_bufid_fifo_rdusedw,
  output logic        o_free_bufid_fifo_rdreq,
  input  logic [8:0]  iv_free_bufid,
  input  logic [3:0]  iv_bufid_req,
  output logic [3:0]  o_pkt_bufid_wr,
  output logic [8:0]  ov_pkt_bufid,
  input  logic [3:0]  i_pkt_bufid_ack,
  output logic [15:0] ov_alloc_cnt,
  output logic [1:0]  ov_bufid_sched_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_t;

  // Every port needs a first bufid after reset, so all start pending.
  localparam logic [3:0] c_pending_rst = 4'b1111;

  state_t      r_state;
  logic        r_rdreq;
  logic [3:0]  r_wr;
  logic [8:0]  r_bufid;
  logic [15:0] r_alloc_cnt;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_grant;
  logic [3:0]  r_pending;

  logic [1:0]  w_search_idx;
  logic [1:0]  w_grant;
  logic        w_grant_valid;
  logic        w_start;
  logic        w_ack_accept;
  logic [3:0]  w_grant_onehot;
  logic [3:0]  w_pending_clr;
  logic [3:0]  w_pending_nxt;

  // --------------------------------------------------------------------------
  // Round-robin search: first pending port at or after r_rr_ptr, wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    w_search_idx  = r_rr_ptr;
    w_grant       = r_rr_ptr;
    w_grant_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_search_idx = r_rr_ptr + 2'(i);
      if (!w_grant_valid && r_pending[w_search_idx]) begin
        w_grant       = w_search_idx;
        w_grant_valid = 1'b1;
      end
    end
  end

  // A fetch only starts when the FIFO holds enough entries; once started,
  // a falling fill level no longer matters because the read is committed.
  assign w_start = (r_state == IDLE) && w_grant_valid &&
                   (iv_free_bufid_fifo_rdusedw >= MIN_FREE);

  assign w_grant_onehot = 4'b0001 << r_grant;

  // Only the granted port's ack, and only while presenting, completes a grant.
  assign w_ack_accept  = (r_state == SEND) && i_pkt_bufid_ack[r_grant];
  assign w_pending_clr = w_ack_accept ? w_grant_onehot : 4'b0000;

  // A new request in the same cycle as the ack wins, so the port is
  // re-queued rather than losing its request.
  assign w_pending_nxt = (r_pending & ~w_pending_clr) | iv_bufid_req;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= c_pending_rst;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Grant FSM. All outputs are registered so they change only on clock
  // edges (or on reset): rdreq is high for the whole READ cycle, the strobe
  // is high for every SEND cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rdreq     <= 1'b0;
      r_wr        <= 4'b0000;
      r_bufid     <= 9'd0;
      r_alloc_cnt <= 16'd0;
      r_rr_ptr    <= 2'd0;
      r_grant     <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_grant <= w_grant;
            r_rdreq <= 1'b1;
            r_state <= READ;
          end
        end
        READ: begin
          r_rdreq <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: begin
          // FIFO data is valid in the cycle after the read request.
          r_bufid <= iv_free_bufid;
          r_wr    <= w_grant_onehot;
          r_state <= SEND;
        end
        SEND: begin
          if (w_ack_accept) begin
            r_wr        <= 4'b0000;
            r_alloc_cnt <= r_alloc_cnt + 16'd1;
            r_rr_ptr    <= r_grant + 2'd1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_free_bufid_fifo_rdreq = r_rdreq;
  assign o_pkt_bufid_wr          = r_wr;
  assign ov_pkt_bufid            = r_bufid;
  assign ov_alloc_cnt            = r_alloc_cnt;
  assign ov_bufid_sched_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pkt_bufid_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pkt_bufid_scheduler
//  Purpose  : Directed self-checking bench for pkt_bufid_scheduler. Expected
//             (port, bufid) pairs are queued when FIFO data is supplied and
//             popped when the write strobe appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_bufid_scheduler;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [8:0]  iv_free_bufid_fifo_rdusedw;
  logic        o_free_bufid_fifo_rdreq;
  logic [8:0]  iv_free_bufid;
  logic [3:0]  iv_bufid_req;
  logic [3:0]  o_pkt_bufid_wr;
  logic [8:0]  ov_pkt_bufid;
  logic [3:0]  i_pkt_bufid_ack;
  logic [15:0] ov_alloc_cnt;
  logic [1:0]  ov_bufid_sched_state;

  typedef struct {
    logic [1:0] port;
    logic [8:0] bufid;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  pkt_bufid_scheduler #(.MIN_FREE(9'd1)) dut (
    .clk_sys                    (clk_sys),
    .reset_n                    (reset_n),
    .iv_free_bufid_fifo_rdusedw (iv_free_bufid_fifo_rdusedw),
    .o_free_bufid_fifo_rdreq    (o_free_bufid_fifo_rdreq),
    .iv_free_bufid              (iv_free_bufid),
    .iv_bufid_req               (iv_bufid_req),
    .o_pkt_bufid_wr             (o_pkt_bufid_wr),
    .ov_pkt_bufid               (ov_pkt_bufid),
    .i_pkt_bufid_ack            (i_pkt_bufid_ack),
    .ov_alloc_cnt               (ov_alloc_cnt),
    .ov_bufid_sched_state       (ov_bufid_sched_state)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for a fetch, supply bufid, expect it on 'port', hold the ack back
  // for 'hold' cycles (with acks on other ports), then ack. With req_same
  // the port re-requests in the ack cycle.
  task automatic serve(input int port, input logic [8:0] bufid, input int hold,
                       input bit req_same, output int wr_cyc);
    int         n;
    exp_t       e;
    logic [3:0] oh;
    logic [3:0] eoh;
    oh       = 4'b0000;
    oh[port] = 1'b1;
    wr_cyc   = 0;
    n        = 0;
    while (o_free_bufid_fifo_rdreq !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("rdreq_seen", 32'(o_free_bufid_fifo_rdreq), 32'd1);
    if (o_free_bufid_fifo_rdreq !== 1'b1) return;
    check("state_read", 32'(ov_bufid_sched_state), 32'd1);
    // Acks outside SEND must be ignored; data here is not yet valid.
    i_pkt_bufid_ack = 4'hF;
    iv_free_bufid   = 9'h1AA;
    tick();
    check("state_wait", 32'(ov_bufid_sched_state), 32'd2);
    check("rdreq_pulse", 32'(o_free_bufid_fifo_rdreq), 32'd0);
    iv_free_bufid = bufid;
    e.port  = port[1:0];
    e.bufid = bufid;
    sb.push_back(e);
    tick();
    i_pkt_bufid_ack = 4'h0;
    iv_free_bufid   = 9'h155;
    wr_cyc = cyc;
    check("state_send", 32'(ov_bufid_sched_state), 32'd3);
    e = sb.pop_front();
    eoh         = 4'b0000;
    eoh[e.port] = 1'b1;
    check("wr_onehot", 32'(o_pkt_bufid_wr), 32'(eoh));
    check("bufid", 32'(ov_pkt_bufid), 32'(e.bufid));
    for (int h = 0; h < hold; h++) begin
      i_pkt_bufid_ack = ~oh;
      tick();
      check("hold_wr", 32'(o_pkt_bufid_wr), 32'(eoh));
      check("hold_bufid", 32'(ov_pkt_bufid), 32'(e.bufid));
      check("hold_state", 32'(ov_bufid_sched_state), 32'd3);
    end
    i_pkt_bufid_ack = oh;
    if (req_same) iv_bufid_req = oh;
    tick();
    i_pkt_bufid_ack = 4'h0;
    iv_bufid_req    = 4'h0;
    check("wr_drop", 32'(o_pkt_bufid_wr), 32'd0);
    check("state_idle", 32'(ov_bufid_sched_state), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int ncyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      if (o_free_bufid_fifo_rdreq !== 1'b0 || o_pkt_bufid_wr !== 4'b0000) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, c3, cnt_before;
    reset_n                    = 1'b0;
    iv_free_bufid_fifo_rdusedw = 9'd100;
    iv_free_bufid              = 9'd0;
    iv_bufid_req               = 4'h0;
    i_pkt_bufid_ack            = 4'h0;
    tick();
    tick();
    check("rst_rdreq", 32'(o_free_bufid_fifo_rdreq), 32'd0);
    check("rst_wr", 32'(o_pkt_bufid_wr), 32'd0);
    check("rst_bufid", 32'(ov_pkt_bufid), 32'd0);
    check("rst_cnt", 32'(ov_alloc_cnt), 32'd0);
    check("rst_state", 32'(ov_bufid_sched_state), 32'd0);

    // Initial fill: all four ports pending, immediate acks.
    reset_n = 1'b1;
    serve(0, 9'd5, 0, 1'b0, c0);
    serve(1, 9'd6, 0, 1'b0, c1);
    serve(2, 9'd7, 0, 1'b0, c2);
    serve(3, 9'd8, 0, 1'b0, c3);
    check("spacing_01", 32'(c1 - c0), 32'd4);
    check("spacing_12", 32'(c2 - c1), 32'd4);
    check("spacing_23", 32'(c3 - c2), 32'd4);
    check("cnt_fill", 32'(ov_alloc_cnt), 32'd4);
    expect_quiet("quiet_after_fill", 10);

    // Two requests, served in round-robin order; rr_ptr returns to 0.
    iv_bufid_req = 4'b1001;
    tick();
    iv_bufid_req = 4'h0;
    serve(0, 9'd20, 0, 1'b0, c0);
    serve(3, 9'd21, 0, 1'b0, c0);
    iv_bufid_req = 4'b1001;
    tick();
    iv_bufid_req = 4'h0;
    serve(0, 9'd22, 0, 1'b0, c0);
    serve(3, 9'd23, 0, 1'b0, c0);
    check("cnt_rr", 32'(ov_alloc_cnt), 32'd8);

    // Request coincident with ack: port 2 is served twice.
    iv_bufid_req = 4'b0100;
    tick();
    iv_bufid_req = 4'h0;
    serve(2, 9'd30, 0, 1'b1, c0);
    serve(2, 9'd31, 0, 1'b0, c0);
    expect_quiet("quiet_after_p2", 10);

    // Port 1 withholds ack for 20 cycles; other acks ignored.
    cnt_before   = 32'(ov_alloc_cnt);
    iv_bufid_req = 4'b0010;
    tick();
    iv_bufid_req = 4'h0;
    serve(1, 9'd40, 20, 1'b0, c0);
    check("cnt_hold", 32'(ov_alloc_cnt), 32'(cnt_before + 1));

    // Empty FIFO after reset: nothing happens until the fill level rises.
    reset_n                    = 1'b0;
    iv_free_bufid_fifo_rdusedw = 9'd0;
    tick();
    reset_n = 1'b1;
    expect_quiet("quiet_empty_fifo", 50);
    check("cnt_after_rst", 32'(ov_alloc_cnt), 32'd0);
    iv_free_bufid_fifo_rdusedw = 9'd1;
    tick();
    check("rdreq_on_fill", 32'(o_free_bufid_fifo_rdreq), 32'd1);
    // Fill level dropping after the grant does not abort it.
    iv_free_bufid_fifo_rdusedw = 9'd0;
    serve(0, 9'd50, 0, 1'b0, c0);
    expect_quiet("quiet_no_underflow", 10);
    iv_free_bufid_fifo_rdusedw = 9'd100;
    serve(1, 9'd51, 0, 1'b0, c0);
    serve(2, 9'd52, 0, 1'b0, c0);
    serve(3, 9'd53, 0, 1'b0, c0);
    check("cnt_refill", 32'(ov_alloc_cnt), 32'd4);

    // Reset asserted mid-handshake.
    iv_bufid_req = 4'b0001;
    tick();
    iv_bufid_req = 4'h0;
    for (int k = 0; k < 20 && o_free_bufid_fifo_rdreq !== 1'b1; k++) tick();
    check("rst_mid_rdreq", 32'(o_free_bufid_fifo_rdreq), 32'd1);
    tick();
    iv_free_bufid = 9'h077;
    tick();
    check("rst_mid_send", 32'(ov_bufid_sched_state), 32'd3);
    check("rst_mid_wr", 32'(o_pkt_bufid_wr), 32'd1);
    check("rst_mid_bufid", 32'(ov_pkt_bufid), 32'h77);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_wr", 32'(o_pkt_bufid_wr), 32'd0);
    check("async_state", 32'(ov_bufid_sched_state), 32'd0);
    check("async_bufid", 32'(ov_pkt_bufid), 32'd0);
    check("async_cnt", 32'(ov_alloc_cnt), 32'd0);
    iv_free_bufid_fifo_rdusedw = 9'd0;
    tick();
    reset_n = 1'b1;
    tick();
    iv_free_bufid_fifo_rdusedw = 9'd100;
    serve(0, 9'd60, 0, 1'b0, c0);
    serve(1, 9'd61, 0, 1'b0, c0);
    serve(2, 9'd62, 0, 1'b0, c0);
    serve(3, 9'd63, 0, 1'b0, c0);
    check("cnt_post_rst", 32'(ov_alloc_cnt), 32'd4);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
